if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipeline.
//  Holds the PC and drives the instruction-memory address. It registers the
//  fetched word and its PC for the decode stage, which feeds immediate
//  generation, the register file and control. It supports hazard stalls and
//  branch/jump redirects with flush.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble word (addi x0,x0,0) placed in IF/ID on reset/flush
//  PC_STEP    4              PC increment per accepted fetch
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   synchronous, active-high reset
//  stall            in   1   hazard unit: hold PC and IF/ID contents
//  redirect         in   1   EX: branch taken / jump; flush IF/ID, load new PC
//  redirect_target  in   32  new PC when redirect=1
//  imem_addr        out  32  instruction memory address (= pc_q, combinational)
//  imem_rdata       in   32  instruction word, combinational read of imem_addr
//  id_pc            out  32  PC of the instruction in IF/ID
//  id_instr         out  32  instruction in IF/ID, fed to decode / immediate generation
//  id_valid         out  1   1 = id_instr is a real fetched instruction, 0 = bubble
//  fetch_count      out  32  number of accepted fetches, wraps modulo 2^32
// BEHAVIOUR
//  Reset (sync, highest priority; overrides redirect and stall):
//   - pc_q=RESET_PC, id_pc=0, id_instr=NOP_INSTR, id_valid=0, fetch_count=0.
//  imem_addr = pc_q at all times; no combinational path from stall/redirect.
//  Per-cycle update priority: reset > redirect > stall > normal.
//  Redirect:
//   - pc_q <= {redirect_target[31:2],2'b00}; low 2 bits are always forced to 0.
//   - id_instr <= NOP_INSTR, id_valid <= 0, id_pc <= 0.
//   - fetch_count unchanged.
//   - Redirect with stall=1 in the same cycle: redirect wins, stall ignored.
//  Stall (redirect=0): pc_q, id_pc, id_instr, id_valid and fetch_count all hold.
//   - Any number of consecutive stall cycles is legal.
//  Normal (accepted fetch):
//   - pc_q <= pc_q+PC_STEP, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
//   - id_pc <= pc_q, id_instr <= imem_rdata, id_valid <= 1.
//   - fetch_count <= fetch_count+1, wraps to 0.
//  Latency: a word at address A appears on id_instr 1 cycle after pc_q==A
//   is accepted.
//  Redirect penalty: 1 bubble. The target instruction is in IF/ID 2 cycles
//   after the redirect cycle.
//  Reset asserted mid-stream (including during stall or redirect): the next
//   edge gives the reset values; the first fetch from RESET_PC follows the
//   first cycle with reset=0.
//  imem_rdata is sampled only in normal cycles; X on imem_rdata during
//   stall/redirect/reset must not propagate.
// TESTING
//  1 reset 2 cycles, ROM words W0..W3 at 0x0..0xC, no stall -> id_pc 0,4,8,C
//    with id_instr W0..W3 on consecutive cycles; id_valid=1 from cycle 1;
//    fetch_count=4.
//  2 stall high 3 cycles while id_pc=4 -> id_pc=4 / id_instr=W1 and
//    fetch_count held 3 cycles, pc_q held; release -> id_pc=8 next.
//  3 redirect=1, target=0x40 at id_pc=8 -> next cycle id_valid=0,
//    id_instr=0x00000013, imem_addr=0x40; cycle after: id_pc=0x40, id_valid=1.
//  4 redirect and stall both high, target=0x23 -> pc_q=0x20 (low bits
//    cleared), bubble inserted, no stall hold.
//  5 redirect to 0xFFFFFFFC, run 2 fetches -> id_pc 0xFFFFFFFC then 0x0;
//    fetch_count preloaded via long run or forced to 0xFFFFFFFF -> wraps to 0.
//  6 reset asserted during a stall with id_valid=1 -> next cycle all outputs
//    at reset values, imem_addr=RESET_PC; reset concurrent with redirect ->
//    reset wins.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Bundle of the fetch-side handshake between the IF/ID stage and its environment:
// hazard/redirect controls, the instruction-memory port and the IF/ID outputs.
interface if_id_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] fetch_count;

    // master is the surrounding pipeline / memory, slave is the fetch stage
    modport master (
        output stall,
        output redirect,
        output redirect_target,
        output imem_rdata,
        input  imem_addr,
        input  id_pc,
        input  id_instr,
        input  id_valid,
        input  fetch_count
    );

    modport slave (
        input  stall,
        input  redirect,
        input  redirect_target,
        input  imem_rdata,
        output imem_addr,
        output id_pc,
        output id_instr,
        output id_valid,
        output fetch_count
    );
endinterface

// File: rtl/if_id_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register: PC generation,
// hazard stall hold, branch/jump redirect with a single-bubble flush.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.slave  bus
);

    logic [31:0] pc_q,         pc_d;
    logic [31:0] idPc_q,       idPc_d;
    logic [31:0] idInstr_q,    idInstr_d;
    logic        idValid_q,    idValid_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    // Priority redirect > stall > fetch; imem_rdata is only consumed on a fetch
    always_comb begin
        pc_d         = pc_q;
        idPc_d       = idPc_q;
        idInstr_d    = idInstr_q;
        idValid_d    = idValid_q;
        fetchCount_d = fetchCount_q;
        if (bus.redirect) begin
            pc_d      = {bus.redirect_target[31:2], 2'b00};
            idPc_d    = 32'h0;
            idInstr_d = NOP_INSTR;
            idValid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d         = pc_q + 32'(PC_STEP);
            idPc_d       = pc_q;
            idInstr_d    = bus.imem_rdata;
            idValid_d    = 1'b1;
            fetchCount_d = fetchCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            idPc_q       <= 32'h0;
            idInstr_q    <= NOP_INSTR;
            idValid_q    <= 1'b0;
            fetchCount_q <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            idPc_q       <= idPc_d;
            idInstr_q    <= idInstr_d;
            idValid_q    <= idValid_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    // Address comes straight from the PC register so stall/redirect never reach imem combinationally
    assign bus.imem_addr   = pc_q;
    assign bus.id_pc       = idPc_q;
    assign bus.id_instr    = idInstr_q;
    assign bus.id_valid    = idValid_q;
    assign bus.fetch_count = fetchCount_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a cycle-level reference model.
module tb_if_id_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    if_id_stage_if bus();

    if_id_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR),
        .PC_STEP   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction ROM content: a distinct word for every address
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        logic [31:0] w;
        w = (addr ^ 32'h9E37_79B9) + {addr[7:0], 24'h5A_0000};
        return w;
    endfunction

    assign bus.imem_rdata = romWord(bus.imem_addr);

    // Reference model state
    logic [31:0] mPc, mIdPc, mIdInstr, mCount;
    logic        mValid;

    task automatic modelStep(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
        if (r) begin
            mPc = RESET_PC; mIdPc = 0; mIdInstr = NOP_INSTR; mValid = 0; mCount = 0;
        end else if (rd) begin
            mPc = tgt & ~32'h3; mIdPc = 0; mIdInstr = NOP_INSTR; mValid = 0;
        end else if (!st) begin
            mIdPc = mPc; mIdInstr = romWord(mPc); mValid = 1;
            mCount = mCount + 1; mPc = mPc + 4;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it
    task automatic applyStimulus(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
        reset               = r;
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        @(posedge clk);
        modelStep(r, st, rd, tgt);
        #1;
        checkOutput("imem_addr",   bus.imem_addr,          mPc);
        checkOutput("id_pc",       bus.id_pc,              mIdPc);
        checkOutput("id_instr",    bus.id_instr,           mIdInstr);
        checkOutput("id_valid",    {31'h0, bus.id_valid},  {31'h0, mValid});
        checkOutput("fetch_count", bus.fetch_count,        mCount);
    endtask

    initial begin
        mPc = 0; mIdPc = 0; mIdInstr = 0; mCount = 0; mValid = 0;
        reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
        @(negedge clk);

        // Reset for two cycles, then two fetches
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_instr", bus.id_instr, 32'h0000_0013);
        checkOutput("rst_addr",  bus.imem_addr, 32'h0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_pc0", bus.id_pc, 32'h0);
        checkOutput("t1_w0",  bus.id_instr, romWord(32'h0));
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_pc4", bus.id_pc, 32'h4);

        // Stall three cycles holding id_pc=4
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("t2_hold_pc",  bus.id_pc, 32'h4);
            checkOutput("t2_hold_w1",  bus.id_instr, romWord(32'h4));
            checkOutput("t2_hold_cnt", bus.fetch_count, 32'd2);
            checkOutput("t2_hold_adr", bus.imem_addr, 32'h8);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_rel_pc", bus.id_pc, 32'h8);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_pcC",  bus.id_pc, 32'hC);
        checkOutput("t1_cnt4", bus.fetch_count, 32'd4);

        // Redirect to 0x40: one bubble, then the target
        applyStimulus(0, 0, 1, 32'h40);
        checkOutput("t3_bub_valid", {31'h0, bus.id_valid}, 32'h0);
        checkOutput("t3_bub_instr", bus.id_instr, 32'h0000_0013);
        checkOutput("t3_addr",      bus.imem_addr, 32'h40);
        checkOutput("t3_cnt",       bus.fetch_count, 32'd4);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_tgt_pc",    bus.id_pc, 32'h40);
        checkOutput("t3_tgt_valid", {31'h0, bus.id_valid}, 32'h1);

        // Redirect with stall, misaligned target
        applyStimulus(0, 1, 1, 32'h23);
        checkOutput("t4_addr",  bus.imem_addr, 32'h20);
        checkOutput("t4_valid", {31'h0, bus.id_valid}, 32'h0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_pc", bus.id_pc, 32'h20);

        // PC wrap at the top of the address space
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_pc_top", bus.id_pc, 32'hFFFF_FFFC);
        checkOutput("t5_addr0",  bus.imem_addr, 32'h0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_pc_wrap", bus.id_pc, 32'h0);

        // Reset during a stall, then reset together with redirect
        applyStimulus(1, 1, 0, 0);
        checkOutput("t6_rst_pc",    bus.id_pc, 32'h0);
        checkOutput("t6_rst_valid", {31'h0, bus.id_valid}, 32'h0);
        checkOutput("t6_rst_cnt",   bus.fetch_count, 32'h0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h80);
        checkOutput("t6_rst_wins", bus.imem_addr, RESET_PC);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6_first_pc",  bus.id_pc, RESET_PC);
        checkOutput("t6_first_cnt", bus.fetch_count, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, st, rd;
            r  = ($urandom_range(0, 49) == 0);
            rd = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0);
            applyStimulus(r, st, rd, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
